game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level sequencer for the dino game's score datapath.
- Runs the IDLE / CLEAR / RUN / DEAD game flow and drives the score counter's stop and clear controls.
- Generates the game tick, whose rate speeds up as the score tens digit rises.
- Latches the high score at the moment of death.

Parameters:
- TICK_DIV, 50000: game-tick period in clock_out cycles at speed level 0.
- TICK_STEP, 4000: cycles removed from the tick period per speed level. TICK_DIV > MAX_LEVEL*TICK_STEP is required.
- MAX_LEVEL, 7: speed level saturation value (fits in 3 bits).
- DEATH_HOLD, 3: game ticks in DEAD during which btn_jump is ignored.

Ports:
- clock_out  in  1  system clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- btn_jump  in  1  jump/start button, debounced and synchronous to clock_out.
- collision  in  1  dino/obstacle overlap, level, synchronous.
- score_units  in  4  BCD units digit from the score counter.
- score_tens  in  4  BCD tens digit from the score counter.
- score_stop  out  1  1 = score counter frozen.
- score_clr  out  1  one-cycle clear pulse to the score counter.
- game_tick  out  1  one-cycle pulse per game step.
- state  out  2  IDLE=0, RUN=1, DEAD=2, CLEAR=3.
- speed_level  out  3  current speed level.
- hi_units  out  4  high score, BCD units.
- hi_tens  out  4  high score, BCD tens.
- new_record  out  1  last death set a new high score.

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE, score_stop=1, score_clr=0, game_tick=0, speed_level=0.
  - hi_units=hi_tens=0, new_record=0.
  - Tick counter, hold counter and button history register all cleared.
- Button edge: jump_edge = btn_jump & ~btn_prev. btn_prev is registered every cycle, including while in IDLE.
- IDLE:
  - score_stop=1; tick counter held at 0.
  - jump_edge -> CLEAR. collision is ignored.
- CLEAR (exactly one cycle):
  - score_clr=1, score_stop=1, new_record<=0.
  - Tick counter and hold counter <=0. Next state is RUN unconditionally.
- RUN:
  - score_stop=0; tick generator active.
  - collision=1 -> DEAD, regardless of jump_edge in the same cycle.
  - On that transition, compare {score_tens,score_units} as an 8-bit unsigned value with {hi_tens,hi_units}.
  - If strictly greater: hi <= score and new_record <= 1. Otherwise hi and new_record are unchanged.
- DEAD:
  - score_stop=1; tick generator keeps running.
  - Hold counter increments on each game_tick, saturating at DEATH_HOLD.
  - While hold < DEATH_HOLD, jump_edge is ignored. Once hold == DEATH_HOLD, jump_edge -> CLEAR.
  - collision is ignored.
- Speed level:
  - Registered every cycle: speed_level <= min(score_tens, MAX_LEVEL).
  - Forced to 0 in IDLE and CLEAR; tracks normally in RUN and DEAD.
- Tick generator:
  - period = TICK_DIV - speed_level*TICK_STEP.
  - Counter increments each cycle in RUN/DEAD.
  - When counter >= period-1: game_tick=1 for that cycle and counter <= 0. The >= covers a period shrinking mid-count.
  - First tick after CLEAR arrives on the TICK_DIV-th cycle of RUN.
- Output timing: score_stop, score_clr and game_tick are registered outputs (no combinational path from inputs).
- Hold counter width: clog2(DEATH_HOLD+1). Tick counter width: clog2(TICK_DIV).
- High score survives all transitions except reset.

Test Plan (TICK_DIV=20, TICK_STEP=2, MAX_LEVEL=7, DEATH_HOLD=2):
- Rst=0 pulse mid-clock, then release -> immediately state=0, score_stop=1, game_tick=0, hi=00, speed_level=0.
- btn_jump 0->1 in IDLE -> next cycle state=3 with score_clr=1 for exactly 1 cycle, then state=1, score_stop=0. First game_tick on the 20th RUN cycle, then every 20 cycles.
- In RUN, score_tens=3 -> speed_level=3 one cycle later; tick spacing 14 cycles. Then score_tens=9 -> speed_level=7, spacing 6.
- Hold btn_jump=1 through IDLE->RUN -> no second start.
- In RUN, collision=1 with score 4,2, hi=00 -> state=2, hi=42, new_record=1.
  - jump_edge before the 2nd DEAD tick -> ignored.
  - jump_edge after it -> CLEAR, new_record=0, hi stays 42.
- In RUN with hi=42, score=3,9, collision and jump_edge in the same cycle -> state=2, hi stays 42, new_record=0.
- Rst=0 asserted mid-RUN -> state=0, score_stop=1, hi=00 without waiting for a clock edge.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow sequencer for the dino score datapath: IDLE/CLEAR/RUN/DEAD control,
// score-scaled game tick generation and high-score capture at death.
module game_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned TICK_STEP  = 4000,
    parameter int unsigned MAX_LEVEL  = 7,
    parameter int unsigned DEATH_HOLD = 3
) (
    input  logic       clock_out,
    input  logic       Rst,
    input  logic       btn_jump,
    input  logic       collision,
    input  logic [3:0] score_units,
    input  logic [3:0] score_tens,
    output logic       score_stop,
    output logic       score_clr,
    output logic       game_tick,
    output logic [1:0] state,
    output logic [2:0] speed_level,
    output logic [3:0] hi_units,
    output logic [3:0] hi_tens,
    output logic       new_record
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = $clog2(DEATH_HOLD + 1);
    localparam int unsigned LW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            btn_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [LW-1:0]   speed_q, speed_d;
    logic            tick_q, tick_d;
    logic            stop_q, stop_d;
    logic            clr_q, clr_d;
    logic            nr_q, nr_d;
    logic [3:0]      hi_u_q, hi_u_d;
    logic [3:0]      hi_t_q, hi_t_d;

    logic            jump_edge_c;
    logic            hold_full_c;
    logic            active_q_c;
    logic            active_d_c;
    logic            new_hi_c;
    logic [LW-1:0]   tens_lvl_c;

    // Last counter value of a tick period at the given speed level.
    function automatic logic [CW-1:0] period_m1(input logic [LW-1:0] lvl);
        return CW'(TICK_DIV - 1 - 32'(lvl) * TICK_STEP);
    endfunction

    assign jump_edge_c = btn_jump & ~btn_prev_q;
    assign hold_full_c = (hold_q == HW'(DEATH_HOLD));
    assign active_q_c  = (state_q == RUN) || (state_q == DEAD);
    assign active_d_c  = (state_d == RUN) || (state_d == DEAD);
    assign new_hi_c    = {score_tens, score_units} > {hi_t_q, hi_u_q};
    assign tens_lvl_c  = (32'(score_tens) > MAX_LEVEL) ? LW'(MAX_LEVEL) : LW'(score_tens);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (jump_edge_c) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (collision) state_d = DEAD;
            DEAD:    if (hold_full_c && jump_edge_c) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output and datapath register.
    always_comb begin
        stop_d  = (state_d != RUN);
        clr_d   = (state_d == CLEAR);
        speed_d = active_d_c ? tens_lvl_c : '0;
        cnt_d   = '0;
        hold_d  = hold_q;
        hi_u_d  = hi_u_q;
        hi_t_d  = hi_t_q;
        nr_d    = nr_q;

        if (active_q_c && active_d_c) begin
            cnt_d = (cnt_q >= period_m1(speed_q)) ? '0 : cnt_q + CW'(1);
        end
        // Tick is precomputed against next cycle's count and period so it lands registered.
        tick_d = active_d_c && (cnt_d >= period_m1(speed_d));

        if (state_d == CLEAR) begin
            hold_d = '0;
        end else if ((state_q == DEAD) && tick_q && !hold_full_c) begin
            hold_d = hold_q + HW'(1);
        end

        if ((state_q == RUN) && collision && new_hi_c) begin
            hi_u_d = score_units;
            hi_t_d = score_tens;
            nr_d   = 1'b1;
        end
        if (state_d == CLEAR) begin
            nr_d = 1'b0;
        end
    end

    always_ff @(posedge clock_out or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            btn_prev_q <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= '0;
            speed_q    <= '0;
            tick_q     <= 1'b0;
            stop_q     <= 1'b1;
            clr_q      <= 1'b0;
            nr_q       <= 1'b0;
            hi_u_q     <= '0;
            hi_t_q     <= '0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn_jump;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            speed_q    <= speed_d;
            tick_q     <= tick_d;
            stop_q     <= stop_d;
            clr_q      <= clr_d;
            nr_q       <= nr_d;
            hi_u_q     <= hi_u_d;
            hi_t_q     <= hi_t_d;
        end
    end

    assign state       = state_q;
    assign score_stop  = stop_q;
    assign score_clr   = clr_q;
    assign game_tick   = tick_q;
    assign speed_level = speed_q;
    assign hi_units    = hi_u_q;
    assign hi_tens     = hi_t_q;
    assign new_record  = nr_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: table of per-cycle vectors checked through a scoreboard queue,
// plus hand-written tick-spacing and asynchronous reset sequences.
module tb_game_ctrl;
    localparam int unsigned TD = 20;
    localparam int unsigned TS = 2;
    localparam int unsigned ML = 7;
    localparam int unsigned DH = 2;
    localparam int NV = 31;

    logic       clock_out = 1'b0;
    logic       Rst = 1'b1;
    logic       btn_jump = 1'b0;
    logic       collision = 1'b0;
    logic [3:0] score_units = 4'd0;
    logic [3:0] score_tens = 4'd0;
    logic       score_stop, score_clr, game_tick, new_record;
    logic [1:0] state;
    logic [2:0] speed_level;
    logic [3:0] hi_units, hi_tens;

    game_ctrl #(
        .TICK_DIV(TD), .TICK_STEP(TS), .MAX_LEVEL(ML), .DEATH_HOLD(DH)
    ) dut (
        .clock_out(clock_out), .Rst(Rst), .btn_jump(btn_jump), .collision(collision),
        .score_units(score_units), .score_tens(score_tens),
        .score_stop(score_stop), .score_clr(score_clr), .game_tick(game_tick),
        .state(state), .speed_level(speed_level),
        .hi_units(hi_units), .hi_tens(hi_tens), .new_record(new_record)
    );

    always #5 clock_out = ~clock_out;

    typedef struct {
        logic       btn;
        logic       coll;
        logic [3:0] u;
        logic [3:0] t;
        logic [1:0] st;
        logic       stop;
        logic       clr;
        logic [2:0] spd;
        logic [7:0] hi;
        logic       nr;
    } vec_t;

    vec_t vecs [NV];
    vec_t exp_q [$];
    int   due_q [$];
    int   idx_q [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clock_out) cyc <= cyc + 1;

    function automatic vec_t mk(logic btn, logic coll, logic [3:0] u, logic [3:0] t,
                                logic [1:0] st, logic stop, logic clr, logic [2:0] spd,
                                logic [7:0] hi, logic nr);
        vec_t v;
        v.btn = btn; v.coll = coll; v.u = u; v.t = t;
        v.st = st; v.stop = stop; v.clr = clr; v.spd = spd; v.hi = hi; v.nr = nr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d, want %0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    // Compare every scoreboard entry whose clock edge has already happened.
    task automatic drain();
        vec_t e;
        int   i;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            i = idx_q.pop_front();
            check("state",      i, int'(state),       int'(e.st));
            check("score_stop", i, int'(score_stop),  int'(e.stop));
            check("score_clr",  i, int'(score_clr),   int'(e.clr));
            check("speed",      i, int'(speed_level), int'(e.spd));
            check("hi",         i, int'({hi_tens, hi_units}), int'(e.hi));
            check("new_record", i, int'(new_record),  int'(e.nr));
        end
    endtask

    // Drive one vector at a falling edge; its expectation is due after the next rising edge.
    task automatic step(input int i);
        btn_jump    = vecs[i].btn;
        collision   = vecs[i].coll;
        score_units = vecs[i].u;
        score_tens  = vecs[i].t;
        exp_q.push_back(vecs[i]);
        due_q.push_back(cyc + 1);
        idx_q.push_back(i);
        @(negedge clock_out);
        drain();
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(i);
    endtask

    // Clock edges from now until game_tick is seen high at a falling edge.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clock_out);
            @(negedge clock_out);
            n++;
        end while (!game_tick && n < 200);
        if (!game_tick) check("tick_timeout", n, 0, 1);
    endtask

    task automatic check_reset(input int tag);
        check("rst_state", tag, int'(state), 0);
        check("rst_stop",  tag, int'(score_stop), 1);
        check("rst_clr",   tag, int'(score_clr), 0);
        check("rst_tick",  tag, int'(game_tick), 0);
        check("rst_speed", tag, int'(speed_level), 0);
        check("rst_hi",    tag, int'({hi_tens, hi_units}), 0);
        check("rst_nr",    tag, int'(new_record), 0);
    endtask

    initial begin
        int n;
        //             btn coll u     t      st    stop clr spd   hi     nr
        vecs[0]  = mk(0, 1, 4'd0, 4'd0, 2'd0, 1, 0, 3'd0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 4'd0, 4'd5, 2'd0, 1, 0, 3'd0, 8'h00, 0);
        vecs[2]  = mk(1, 0, 4'd0, 4'd0, 2'd3, 1, 1, 3'd0, 8'h00, 0);
        vecs[3]  = mk(1, 0, 4'd0, 4'd0, 2'd1, 0, 0, 3'd0, 8'h00, 0);
        vecs[4]  = mk(1, 0, 4'd0, 4'd0, 2'd1, 0, 0, 3'd0, 8'h00, 0);
        vecs[5]  = mk(0, 0, 4'd0, 4'd3, 2'd1, 0, 0, 3'd3, 8'h00, 0);
        vecs[6]  = mk(0, 0, 4'd0, 4'd9, 2'd1, 0, 0, 3'd7, 8'h00, 0);
        vecs[7]  = mk(0, 1, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 1);
        vecs[8]  = mk(0, 0, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 1);
        vecs[9]  = mk(1, 0, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 1);
        vecs[10] = mk(0, 0, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 1);
        vecs[11] = mk(1, 1, 4'd9, 4'd9, 2'd2, 1, 0, 3'd7, 8'h42, 1);
        vecs[12] = mk(0, 0, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 1);
        vecs[13] = mk(1, 0, 4'd2, 4'd4, 2'd3, 1, 1, 3'd0, 8'h42, 0);
        vecs[14] = mk(1, 0, 4'd9, 4'd3, 2'd1, 0, 0, 3'd3, 8'h42, 0);
        vecs[15] = mk(0, 0, 4'd9, 4'd3, 2'd1, 0, 0, 3'd3, 8'h42, 0);
        vecs[16] = mk(1, 1, 4'd9, 4'd3, 2'd2, 1, 0, 3'd3, 8'h42, 0);
        vecs[17] = mk(0, 0, 4'd9, 4'd3, 2'd2, 1, 0, 3'd3, 8'h42, 0);
        vecs[18] = mk(0, 0, 4'd9, 4'd3, 2'd2, 1, 0, 3'd3, 8'h42, 0);
        vecs[19] = mk(1, 0, 4'd9, 4'd3, 2'd3, 1, 1, 3'd0, 8'h42, 0);
        vecs[20] = mk(0, 0, 4'd2, 4'd4, 2'd1, 0, 0, 3'd4, 8'h42, 0);
        vecs[21] = mk(0, 1, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 0);
        vecs[22] = mk(0, 0, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 0);
        vecs[23] = mk(0, 0, 4'd2, 4'd4, 2'd2, 1, 0, 3'd4, 8'h42, 0);
        vecs[24] = mk(1, 0, 4'd2, 4'd4, 2'd3, 1, 1, 3'd0, 8'h42, 0);
        vecs[25] = mk(0, 0, 4'd3, 4'd4, 2'd1, 0, 0, 3'd4, 8'h42, 0);
        vecs[26] = mk(0, 1, 4'd3, 4'd4, 2'd2, 1, 0, 3'd4, 8'h43, 1);
        vecs[27] = mk(0, 0, 4'd3, 4'd4, 2'd2, 1, 0, 3'd4, 8'h43, 1);
        vecs[28] = mk(0, 0, 4'd3, 4'd4, 2'd2, 1, 0, 3'd4, 8'h43, 1);
        vecs[29] = mk(1, 0, 4'd3, 4'd4, 2'd3, 1, 1, 3'd0, 8'h43, 0);
        vecs[30] = mk(0, 0, 4'd3, 4'd4, 2'd1, 0, 0, 3'd4, 8'h43, 0);

        // Asynchronous reset between clock edges.
        #3 Rst = 1'b0;
        #1 check_reset(0);
        @(negedge clock_out);
        @(negedge clock_out);
        Rst = 1'b1;
        @(negedge clock_out);

        // Start from IDLE; the check of vector 3 is RUN cycle 1, so RUN cycle 20 is 19 edges on.
        run_vecs(0, 3);
        wait_tick(n); check("first_tick", 0, n, 19);
        wait_tick(n); check("tick_gap_l0", 0, n, 20);
        run_vecs(4, 5);
        wait_tick(n);
        wait_tick(n); check("tick_gap_l3", 0, n, 14);
        step(6);
        wait_tick(n);
        wait_tick(n); check("tick_gap_l7", 0, n, 6);

        // Death with a new record, then the hold-off window.
        run_vecs(7, 8);
        wait_tick(n);
        run_vecs(9, 10);
        wait_tick(n); check("dead_tick_gap", 0, n, 10);
        run_vecs(11, 17);
        wait_tick(n);
        wait_tick(n);
        run_vecs(18, 22);
        wait_tick(n);
        wait_tick(n);
        run_vecs(23, 27);
        wait_tick(n);
        wait_tick(n);
        run_vecs(28, 30);

        // Asynchronous reset in the middle of RUN.
        #2 Rst = 1'b0;
        #1 check_reset(1);
        check("sb_left", 0, due_q.size(), 0);
        @(negedge clock_out);
        Rst = 1'b1;
        @(negedge clock_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
